prbs_15_checker: RTL and testbench

PRBS_15_CHECKER -- requirements
Module: prbs_15_checker

---
 rtl/prbs_15_checker.sv | 175 +++++++++++++++++
 tb/tb_prbs_15_checker.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_15_checker.sv
// PRBS-15 (x^15+x^14+1) checker: hunts for a repeated 4-byte header, seeds from two bytes, then checks bytes.
// Defining PRBS_BIT_ERR_CNT_EN adds the saturating bit_err_cnt output.
module prbs_15_checker #(
    parameter logic [7:0]  PAT0    = 8'hCC,
    parameter logic [7:0]  PAT1    = 8'hDD,
    parameter logic [7:0]  PAT2    = 8'hEE,
    parameter logic [7:0]  PAT3    = 8'hFF,
    parameter int unsigned LOS_THR = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    input  logic [1:0]  n,
    output logic        pattern_found,
    output logic        locked,
    output logic        err_byte,
    output logic [15:0] err_cnt
`ifdef PRBS_BIT_ERR_CNT_EN
    ,
    output logic [15:0] bit_err_cnt
`endif
);

    typedef enum logic [1:0] {HUNT, HEADER, SYNC, CHECK} state_e;

    localparam logic [3:0] LOS_THR_C = 4'(LOS_THR);

    state_e      state_q;
    logic [1:0]  idx_q;
    logic [1:0]  rep_q;
    logic [1:0]  n_eff_q;
    logic        sync_cnt_q;
    logic [14:0] r_q;
    logic [3:0]  consec_q;
    logic        pattern_found_q;
    logic        locked_q;
    logic        err_byte_q;
    logic [15:0] err_cnt_q;

    logic [7:0]  hdr_exp_d;
    logic [22:0] win_d;
    logic [7:0]  mis_vec_d;
    logic [14:0] r_next_d;

    always_comb begin
        hdr_exp_d = PAT0;
        unique case (idx_q)
            2'd0: hdr_exp_d = PAT0;
            2'd1: hdr_exp_d = PAT1;
            2'd2: hdr_exp_d = PAT2;
            2'd3: hdr_exp_d = PAT3;
            default: hdr_exp_d = PAT0;
        endcase
    end

    // Oldest bit at the top: each received bit is predicted from the bits 15 and 14 positions earlier.
    assign win_d    = {r_q, data_in};
    assign r_next_d = win_d[14:0];

    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
        assign mis_vec_d[gi] = win_d[gi] ^ win_d[gi + 15] ^ win_d[gi + 14];
    end

`ifdef PRBS_BIT_ERR_CNT_EN
    logic [15:0] bit_err_cnt_q;
    logic [3:0]  mis_cnt_d;
    logic [16:0] bit_sum_d;

    always_comb begin
        mis_cnt_d = '0;
        for (int i = 0; i < 8; i++) begin
            mis_cnt_d = mis_cnt_d + {3'b000, mis_vec_d[i]};
        end
    end

    assign bit_sum_d = {1'b0, bit_err_cnt_q} + {13'd0, mis_cnt_d};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_err_cnt_q <= '0;
        end else if (data_valid && state_q == CHECK) begin
            bit_err_cnt_q <= bit_sum_d[16] ? 16'hFFFF : bit_sum_d[15:0];
        end
    end

    assign bit_err_cnt = bit_err_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= HUNT;
            idx_q           <= '0;
            rep_q           <= '0;
            n_eff_q         <= 2'd1;
            sync_cnt_q      <= 1'b0;
            r_q             <= '0;
            consec_q        <= '0;
            pattern_found_q <= 1'b0;
            locked_q        <= 1'b0;
            err_byte_q      <= 1'b0;
            err_cnt_q       <= '0;
        end else begin
            pattern_found_q <= 1'b0;
            err_byte_q      <= 1'b0;
            if (data_valid) begin
                unique case (state_q)
                    HUNT: begin
                        if (data_in == PAT0) begin
                            state_q <= HEADER;
                            idx_q   <= 2'd1;
                            rep_q   <= 2'd0;
                            n_eff_q <= (n == 2'd0) ? 2'd1 : n;
                        end
                    end
                    HEADER: begin
                        if (data_in == hdr_exp_d) begin
                            if (idx_q == 2'd3) begin
                                if (rep_q == n_eff_q - 2'd1) begin
                                    pattern_found_q <= 1'b1;
                                    state_q         <= SYNC;
                                    sync_cnt_q      <= 1'b0;
                                end else begin
                                    idx_q <= 2'd0;
                                    rep_q <= rep_q + 2'd1;
                                end
                            end else begin
                                idx_q <= idx_q + 2'd1;
                            end
                        end else if (data_in == PAT0) begin
                            idx_q <= 2'd1;
                            rep_q <= 2'd0;
                        end else begin
                            state_q <= HUNT;
                        end
                    end
                    SYNC: begin
                        r_q        <= {r_q[6:0], data_in};
                        sync_cnt_q <= 1'b1;
                        if (sync_cnt_q) begin
                            state_q  <= CHECK;
                            locked_q <= 1'b1;
                            consec_q <= '0;
                        end
                    end
                    CHECK: begin
                        r_q <= r_next_d;
                        if (|mis_vec_d) begin
                            err_byte_q <= 1'b1;
                            if (err_cnt_q != 16'hFFFF) begin
                                err_cnt_q <= err_cnt_q + 16'd1;
                            end
                            if (consec_q == LOS_THR_C - 4'd1) begin
                                state_q  <= HUNT;
                                locked_q <= 1'b0;
                                consec_q <= '0;
                            end else begin
                                consec_q <= consec_q + 4'd1;
                            end
                        end else begin
                            consec_q <= '0;
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign pattern_found = pattern_found_q;
    assign locked        = locked_q;
    assign err_byte      = err_byte_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_prbs_15_checker.sv
// Self-checking bench for prbs_15_checker: directed scenarios plus randomized episodes against a bit-stream model.
module tb_prbs_15_checker;

    localparam logic [7:0] PAT0 = 8'hCC;
    localparam logic [7:0] PAT1 = 8'hDD;
    localparam logic [7:0] PAT2 = 8'hEE;
    localparam logic [7:0] PAT3 = 8'hFF;
    localparam int LOS_THR = 4;

    localparam int M_HUNT  = 0;
    localparam int M_HDR   = 1;
    localparam int M_SYNC  = 2;
    localparam int M_CHECK = 3;

    logic        clk;
    logic        rst;
    logic [7:0]  data_in;
    logic        data_valid;
    logic [1:0]  n_in;
    logic        pattern_found;
    logic        locked;
    logic        err_byte;
    logic [15:0] err_cnt;
`ifdef PRBS_BIT_ERR_CNT_EN
    logic [15:0] bit_err_cnt;
`endif

    prbs_15_checker #(
        .PAT0(PAT0), .PAT1(PAT1), .PAT2(PAT2), .PAT3(PAT3), .LOS_THR(LOS_THR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .data_valid(data_valid),
        .n(n_in),
        .pattern_found(pattern_found),
        .locked(locked),
        .err_byte(err_byte),
        .err_cnt(err_cnt)
`ifdef PRBS_BIT_ERR_CNT_EN
        ,
        .bit_err_cnt(bit_err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit idle_on = 1'b0;

    // Reference model: header progress as a byte count, check state as the history of received bits.
    int m_state, m_pos, m_neff, m_sync, m_consec, m_errcnt, m_biterr;
    bit m_pf, m_eb;
    bit mh[$];

    // Transmit generator: s[i] = s[i-15] ^ s[i-14], seeded with fifteen ones.
    bit gq[$];
    int gcount;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat_of(input int i);
        case (i)
            0: return PAT0;
            1: return PAT1;
            2: return PAT2;
            default: return PAT3;
        endcase
    endfunction

    task automatic model_reset();
        m_state = M_HUNT; m_pos = 0; m_neff = 1; m_sync = 0; m_consec = 0;
        m_errcnt = 0; m_biterr = 0; m_pf = 0; m_eb = 0;
        mh.delete();
    endtask

    task automatic model_accept(input logic [7:0] b, input logic [1:0] nv);
        int nb;
        bit pred;
        m_pf = 0;
        m_eb = 0;
        case (m_state)
            M_HUNT: if (b == PAT0) begin
                m_state = M_HDR; m_pos = 1; m_neff = (nv == 2'd0) ? 1 : int'(nv);
            end
            M_HDR: begin
                if (b == pat_of(m_pos % 4)) begin
                    m_pos++;
                    if (m_pos == 4 * m_neff) begin
                        m_pf = 1; m_state = M_SYNC; m_sync = 0;
                    end
                end else if (b == PAT0) begin
                    m_pos = 1;
                end else begin
                    m_state = M_HUNT;
                end
            end
            M_SYNC: begin
                for (int i = 7; i >= 0; i--) begin
                    mh.push_back(b[i]);
                    if (mh.size() > 15) void'(mh.pop_front());
                end
                m_sync++;
                if (m_sync == 2) begin
                    m_state = M_CHECK; m_consec = 0;
                end
            end
            default: begin
                nb = 0;
                for (int i = 7; i >= 0; i--) begin
                    pred = mh[0] ^ mh[1];
                    if (b[i] != pred) nb++;
                    mh.push_back(b[i]);
                    void'(mh.pop_front());
                end
                m_biterr = (m_biterr + nb > 65535) ? 65535 : m_biterr + nb;
                if (nb > 0) begin
                    m_eb = 1;
                    if (m_errcnt < 65535) m_errcnt++;
                    m_consec++;
                    if (m_consec == LOS_THR) begin
                        m_state = M_HUNT; m_consec = 0;
                    end
                end else begin
                    m_consec = 0;
                end
            end
        endcase
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".pf"}, pattern_found, m_pf);
        chk({tag, ".locked"}, locked, (m_state == M_CHECK));
        chk({tag, ".err_byte"}, err_byte, m_eb);
        chk({tag, ".err_cnt"}, err_cnt, m_errcnt);
`ifdef PRBS_BIT_ERR_CNT_EN
        chk({tag, ".bit_err_cnt"}, bit_err_cnt, m_biterr);
`endif
    endtask

    task automatic idle();
        @(negedge clk);
        data_valid = 1'b0;
        data_in = 8'($urandom);
        @(posedge clk);
        #1;
        m_pf = 0;
        m_eb = 0;
        check_outputs("idle");
    endtask

    task automatic send(input logic [7:0] b);
        if (idle_on && $urandom_range(0, 3) == 0) idle();
        @(negedge clk);
        data_in = b;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        model_accept(b, n_in);
        check_outputs("byte");
    endtask

    task automatic gen_reset();
        gq.delete();
        gcount = 0;
    endtask

    function automatic logic [7:0] gen_byte(input logic [7:0] mask, input bit follow_tx);
        logic [7:0] v;
        bit b;
        for (int i = 7; i >= 0; i--) begin
            b = (gcount < 15) ? 1'b1 : (gq[0] ^ gq[1]);
            v[i] = b ^ mask[i];
            gq.push_back(follow_tx ? v[i] : b);
            if (gq.size() > 15) void'(gq.pop_front());
            gcount++;
        end
        return v;
    endfunction

    task automatic send_header(input int reps);
        for (int r = 0; r < reps; r++) begin
            send(PAT0); send(PAT1); send(PAT2); send(PAT3);
        end
    endtask

    task automatic async_reset();
        #3;
        rst = 1'b0;
        #1;
        chk("rst.pf", pattern_found, 0);
        chk("rst.locked", locked, 0);
        chk("rst.err_byte", err_byte, 0);
        chk("rst.err_cnt", err_cnt, 0);
`ifdef PRBS_BIT_ERR_CNT_EN
        chk("rst.bit_err_cnt", bit_err_cnt, 0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit eb_seen;
        int bit_base;
        logic [7:0] b;
        int reps;

        rst = 1'b0;
        data_in = 8'h00;
        data_valid = 1'b0;
        n_in = 2'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        idle();

        // Broken header with n=0: FSM falls back to HUNT.
        n_in = 2'd0;
        send(PAT0); send(PAT1); send(8'h00); send(PAT3);
        chk("bad_hdr.locked", locked, 0);

        // Single header with n=0 locks after the two seed bytes.
        send_header(1);
        chk("n0.pf", pattern_found, 1);
        gen_reset();
        send(gen_byte(8'h00, 1'b0));
        chk("n0.sync1.locked", locked, 0);
        send(gen_byte(8'h00, 1'b0));
        chk("n0.sync2.locked", locked, 1);

        // Four A5 bytes right after seeding are all errored: loss of lock.
        for (int i = 1; i <= 4; i++) begin
            send(8'hA5);
            chk("los.err_cnt", err_cnt, i);
            chk("los.locked", locked, (i < 4));
        end

        // n=2: pulse only on the eighth header byte.
        idle_on = 1'b1;
        n_in = 2'd2;
        send(PAT0); send(PAT1); send(PAT2); send(PAT3);
        send(PAT0); send(PAT1); send(PAT2);
        chk("n2.pf7", pattern_found, 0);
        send(PAT3);
        chk("n2.pf8", pattern_found, 1);
        gen_reset();
        send(gen_byte(8'h00, 1'b0));
        chk("n2.sync1.locked", locked, 0);
        send(gen_byte(8'h00, 1'b0));
        chk("n2.sync2.locked", locked, 1);

        // 200 clean PRBS bytes.
        eb_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            send(gen_byte(8'h00, 1'b0));
            if (err_byte !== 1'b0) eb_seen = 1'b1;
        end
        chk("clean.eb_seen", eb_seen, 0);
        chk("clean.err_cnt", err_cnt, 4);
        chk("clean.locked", locked, 1);

        // MSB flip echoes into the next byte through the feedback taps.
        bit_base = m_biterr;
        send(gen_byte(8'h80, 1'b0));
        chk("flip.k", err_byte, 1);
        send(gen_byte(8'h00, 1'b0));
        chk("flip.k1", err_byte, 1);
        send(gen_byte(8'h00, 1'b0));
        chk("flip.k2", err_byte, 0);
        chk("flip.err_cnt", err_cnt, 6);
        chk("flip.locked", locked, 1);
`ifdef PRBS_BIT_ERR_CNT_EN
        chk("flip.bit_err_cnt", bit_err_cnt, bit_base + 3);
`endif

        // Randomized episodes: garbage, corrupted headers, changing n, and noisy PRBS.
        for (int e = 0; e < 30; e++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
                    b = ($urandom_range(0, 3) == 0) ? PAT0 : 8'($urandom);
                    send(b);
                end
            end else begin
                n_in = 2'($urandom);
                reps = (n_in == 2'd0) ? 1 : int'(n_in);
                for (int j = 0; j < 4 * reps; j++) begin
                    b = pat_of(j % 4);
                    if ($urandom_range(0, 9) == 0) b = 8'($urandom);
                    if ($urandom_range(0, 3) == 0) n_in = 2'($urandom);
                    send(b);
                end
                gen_reset();
                for (int j = 0; j < int'($urandom_range(12, 32)); j++) begin
                    b = ($urandom_range(0, 11) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
                    send(gen_byte(b, 1'b0));
                end
            end
        end

        // Exactly five isolated errored bytes, then an asynchronous reset mid-CHECK.
        idle_on = 1'b0;
        async_reset();
        n_in = 2'd1;
        send_header(1);
        gen_reset();
        send(gen_byte(8'h00, 1'b1));
        send(gen_byte(8'h00, 1'b1));
        for (int i = 0; i < 5; i++) begin
            send(gen_byte(8'h01, 1'b1));
            send(gen_byte(8'h00, 1'b1));
        end
        chk("pre_rst.err_cnt", err_cnt, 5);
        chk("pre_rst.locked", locked, 1);
        async_reset();

        // First bytes after release are evaluated in HUNT.
        send(PAT1); send(PAT2); send(PAT3);
        chk("post_rst.locked", locked, 0);
        send_header(1);
        chk("post_rst.pf", pattern_found, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
